// File: rtl/tastable_pkg.sv
// Shared definitions for the SNES reset sequencer.
// Holds the FSM state encoding, the default hold/timeout lengths and the
// console-hold unit (cmd_hold counts in units of 2**P_HOLD_UNIT_LOG2 cycles).
package tastable_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MCLK_HOLD = 3'd1,
      ST_CON_HOLD  = 3'd2,
      ST_WAIT_SYNC = 3'd3,
      ST_WAIT_CPU  = 3'd4,
      ST_RUN       = 3'd5,
      ST_FAULT     = 3'd6
   } state_t;

   localparam int P_MCLK_HOLD      = 16;
   localparam int P_CON_HOLD       = 1024;
   localparam int P_SYNC_TIMEOUT   = 1 << 20;
   localparam int P_CPU_TIMEOUT    = 4096;
   localparam int P_HOLD_UNIT_LOG2 = 8;
   localparam int P_HOLD_UNIT      = 1 << P_HOLD_UNIT_LOG2;

endpackage

// File: rtl/snes_reset_sequencer_if.sv
// Host command/status bus of the reset sequencer.
//   cmd_valid/cmd_ready : start handshake
//   cmd_hold            : console hold in 256-cycle units (0 = default)
//   busy/done/error     : sequence status
//   sync_latency        : captured WAIT_SYNC count
// master = host side, slave = sequencer side.
interface snes_reset_sequencer_if #(
   parameter int CNT_W = 24
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [15:0]      cmd_hold;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] sync_latency;

   modport master (
      output cmd_valid, cmd_hold,
      input  cmd_ready, busy, done, error, sync_latency
   );

   modport slave (
      input  cmd_valid, cmd_hold,
      output cmd_ready, busy, done, error, sync_latency
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a parameterised reset (idle) value.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronized output
module sync_2ff #(
   parameter logic IDLE = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= IDLE;
         r_sync <= IDLE;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/snes_reset_sequencer.sv
// Power-on/reset sequencer ahead of the master-clock divider and APU/CPU
// clock generator. Holds the divider reset, then the console reset, releases
// them in order, then waits for the APU sync strobe and CPU-reset release.
//   i_clkin           : master clock
//   i_reset           : asynchronous active-low block reset
//   bus (slave)       : host command/status bus
//   i_apusync         : async active-low APU sync strobe
//   i_cpureset_in     : async CPU-reset release (1 = CPU running)
//   o_mclkreset_n     : divider reset, active-low
//   o_console_reset_n : console reset, active-low
//
// state        | meaning
// ST_IDLE      | waiting for first command
// ST_MCLK_HOLD | divider and console held in reset
// ST_CON_HOLD  | divider released, console still held
// ST_WAIT_SYNC | both released, counting until APU sync falls
// ST_WAIT_CPU  | waiting for the generator to release the CPU
// ST_RUN       | sequence complete, watching for CPU reset loss
// ST_FAULT     | timeout or CPU reset loss, console held in reset
module snes_reset_sequencer
   import tastable_pkg::*;
#(
   parameter int MCLK_HOLD    = P_MCLK_HOLD,
   parameter int CON_HOLD_DEF = P_CON_HOLD,
   parameter int SYNC_TIMEOUT = P_SYNC_TIMEOUT,
   parameter int CPU_TIMEOUT  = P_CPU_TIMEOUT,
   parameter int CNT_W        = 24
) (
   input  logic                  i_clkin,
   input  logic                  i_reset,
   snes_reset_sequencer_if.slave bus,
   input  logic                  i_apusync,
   input  logic                  i_cpureset_in,
   output logic                  o_mclkreset_n,
   output logic                  o_console_reset_n
);
   localparam logic [CNT_W-1:0] L_MCLK_LAST = CNT_W'(MCLK_HOLD);
   localparam logic [CNT_W-1:0] L_CON_DEF   = CNT_W'(CON_HOLD_DEF);
   localparam logic [CNT_W-1:0] L_SYNC_LAST = CNT_W'(SYNC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] L_CPU_LAST  = CNT_W'(CPU_TIMEOUT - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [CNT_W-1:0] r_lat, w_lat_nxt;
   logic [CNT_W-1:0] w_hold_len, w_con_last;
   logic [15:0]      r_hold, w_hold_nxt;
   logic             r_ready, w_ready_nxt;
   logic             r_mclk, w_mclk_nxt;
   logic             r_con, w_con_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic             w_fault;
   logic             w_apu_s, r_apu_d, w_apu_fall;
   logic             w_cpu_s;
   logic             w_accept;

   sync_2ff #(.IDLE(1'b1)) u_sync_apu (
      .i_clk(i_clkin), .i_rst_n(i_reset), .i_d(i_apusync), .o_q(w_apu_s)
   );

   sync_2ff #(.IDLE(1'b0)) u_sync_cpu (
      .i_clk(i_clkin), .i_rst_n(i_reset), .i_d(i_cpureset_in), .o_q(w_cpu_s)
   );

   always_ff @(posedge i_clkin or negedge i_reset) begin
      if (!i_reset) r_apu_d <= 1'b1;
      else          r_apu_d <= w_apu_s;
   end

   assign w_apu_fall = r_apu_d & ~w_apu_s;
   assign w_accept   = bus.cmd_valid & r_ready;
   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_hold_len = (r_hold == 16'd0) ? L_CON_DEF
                                         : (CNT_W'(r_hold) << P_HOLD_UNIT_LOG2);
   // Compare against H-1 so the console release lands exactly H cycles
   // after the divider release.
   assign w_con_last = w_hold_len - 1'b1;

   always_ff @(posedge i_clkin or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_lat   <= '0;
         r_hold  <= '0;
         r_ready <= 1'b0;
         r_mclk  <= 1'b0;
         r_con   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lat   <= w_lat_nxt;
         r_hold  <= w_hold_nxt;
         r_ready <= w_ready_nxt;
         r_mclk  <= w_mclk_nxt;
         r_con   <= w_con_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_inc;
      w_lat_nxt   = r_lat;
      w_hold_nxt  = r_hold;
      w_mclk_nxt  = r_mclk;
      w_con_nxt   = r_con;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_err_nxt   = r_err;
      w_fault     = 1'b0;

      if (w_accept) begin
         w_state_nxt = ST_MCLK_HOLD;
         w_cnt_nxt   = '0;
         w_hold_nxt  = bus.cmd_hold;
         w_mclk_nxt  = 1'b0;
         w_con_nxt   = 1'b0;
         w_busy_nxt  = 1'b1;
         w_done_nxt  = 1'b0;
         w_err_nxt   = 1'b0;
      end else begin
         unique case (r_state)
            ST_MCLK_HOLD: begin
               if (r_cnt == L_MCLK_LAST) begin
                  w_state_nxt = ST_CON_HOLD;
                  w_cnt_nxt   = '0;
                  w_mclk_nxt  = 1'b1;
               end
            end
            ST_CON_HOLD: begin
               if (r_cnt == w_con_last) begin
                  w_state_nxt = ST_WAIT_SYNC;
                  w_cnt_nxt   = '0;
                  w_con_nxt   = 1'b1;
               end
            end
            ST_WAIT_SYNC: begin
               // Edge is tested first so it wins over a same-cycle timeout.
               if (w_apu_fall) begin
                  w_state_nxt = ST_WAIT_CPU;
                  w_cnt_nxt   = '0;
                  w_lat_nxt   = r_cnt;
               end else if (r_cnt == L_SYNC_LAST) begin
                  w_fault = 1'b1;
               end
            end
            ST_WAIT_CPU: begin
               if (w_cpu_s) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else if (r_cnt == L_CPU_LAST) begin
                  w_fault = 1'b1;
               end
            end
            ST_RUN: begin
               w_cnt_nxt = '0;
               if (!w_cpu_s) w_fault = 1'b1;
            end
            ST_IDLE, ST_FAULT: w_cnt_nxt = '0;
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase

         if (w_fault) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
            w_con_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
         end
      end

      w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN) ||
                    (w_state_nxt == ST_FAULT);
   end

   assign bus.cmd_ready     = r_ready;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.error         = r_err;
   assign bus.sync_latency  = r_lat;
   assign o_mclkreset_n     = r_mclk;
   assign o_console_reset_n = r_con;
endmodule

// File: tb/tb_snes_reset_sequencer.sv
// Directed bench for snes_reset_sequencer with short timeouts.
module tb_snes_reset_sequencer;
   logic clk;
   logic rst_n;
   logic apusync;
   logic cpurst;
   logic mclk_n;
   logic con_n;
   int   cyc;
   int   n_vec;
   int   n_err;
   int   t_acc, t_mclk, t_con, t_ev;

   snes_reset_sequencer_if #(.CNT_W(24)) bus ();

   snes_reset_sequencer #(
      .MCLK_HOLD(16), .CON_HOLD_DEF(1024), .SYNC_TIMEOUT(4096),
      .CPU_TIMEOUT(256), .CNT_W(24)
   ) dut (
      .i_clkin(clk), .i_reset(rst_n), .bus(bus),
      .i_apusync(apusync), .i_cpureset_in(cpurst),
      .o_mclkreset_n(mclk_n), .o_console_reset_n(con_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return mclk_n;
         1:       return con_n;
         2:       return bus.done;
         default: return bus.error;
      endcase
   endfunction

   // Returns the cycle stamp at which the signal first reads val, or -1.
   task automatic wait_sig(input int which, input logic val, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk); #1;
         if (sig(which) === val) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic start_cmd(input logic [15:0] hold, output int at);
      bus.cmd_valid = 1'b1;
      bus.cmd_hold  = hold;
      @(posedge clk); #1;
      at = cyc;
      bus.cmd_valid = 1'b0;
      bus.cmd_hold  = 16'd0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      apusync = 1'b1;
      cpurst = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_hold  = 16'd0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.cmd_ready, 0);
      chk("rst_mclk", mclk_n, 0);
      chk("rst_con", con_n, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_lat", bus.sync_latency, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_ready", bus.cmd_ready, 1);

      // nominal run, default hold
      start_cmd(16'd0, t_acc);
      chk("nom_busy", bus.busy, 1);
      chk("nom_ready_low", bus.cmd_ready, 0);
      chk("nom_mclk_low", mclk_n, 0);
      wait_sig(0, 1'b1, 40, t_mclk);
      chk("nom_mclk_rise", t_mclk - t_acc, 17);
      chk("nom_con_held", con_n, 0);
      wait_sig(1, 1'b1, 1100, t_con);
      chk("nom_con_rise", t_con - t_mclk, 1024);
      repeat (300) @(posedge clk);
      #1 apusync = 1'b0;
      repeat (50) @(posedge clk);
      #1 cpurst = 1'b1;
      wait_sig(2, 1'b1, 20, t_ev);
      chk("nom_done_seen", t_ev > 0, 1);
      chk("nom_lat_range", (bus.sync_latency >= 302) && (bus.sync_latency <= 303), 1);
      chk("nom_error", bus.error, 0);
      chk("nom_busy_end", bus.busy, 0);
      chk("nom_ready_run", bus.cmd_ready, 1);
      apusync = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // restart from RUN with cmd_hold=3, ignored pulse during CON_HOLD
      start_cmd(16'd3, t_acc);
      chk("rs_done_clr", bus.done, 0);
      chk("rs_busy", bus.busy, 1);
      chk("rs_con_low", con_n, 0);
      wait_sig(0, 1'b1, 40, t_mclk);
      chk("rs_mclk_rise", t_mclk - t_acc, 17);
      repeat (100) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_hold  = 16'd7;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_hold  = 16'd0;
      chk("rs_pulse_busy", bus.busy, 1);
      wait_sig(1, 1'b1, 800, t_con);
      chk("rs_con_768", t_con - t_mclk, 768);
      repeat (10) @(posedge clk);
      #1 apusync = 1'b0;
      wait_sig(2, 1'b1, 20, t_ev);
      chk("rs_done_seen", t_ev > 0, 1);
      chk("rs_lat_range", (bus.sync_latency >= 12) && (bus.sync_latency <= 13), 1);
      apusync = 1'b1;

      // CPU reset lost during RUN
      cpurst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("drop_error", bus.error, 1);
      chk("drop_con", con_n, 0);
      chk("drop_done", bus.done, 0);
      chk("drop_mclk", mclk_n, 1);
      chk("drop_ready", bus.cmd_ready, 1);

      // no APU sync: timeout fault
      start_cmd(16'd1, t_acc);
      chk("to_err_clr", bus.error, 0);
      wait_sig(0, 1'b1, 40, t_mclk);
      wait_sig(1, 1'b1, 300, t_con);
      chk("to_con_256", t_con - t_mclk, 256);
      wait_sig(3, 1'b1, 4200, t_ev);
      chk("to_fault_time", t_ev - t_con, 4096);
      chk("to_con", con_n, 0);
      chk("to_mclk", mclk_n, 1);
      chk("to_ready", bus.cmd_ready, 1);
      chk("to_busy", bus.busy, 0);

      // async reset mid-WAIT_SYNC
      start_cmd(16'd1, t_acc);
      wait_sig(1, 1'b1, 400, t_con);
      chk("ar_con_up", con_n, 1);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_con", con_n, 0);
      chk("ar_mclk", mclk_n, 0);
      chk("ar_busy", bus.busy, 0);
      chk("ar_ready", bus.cmd_ready, 0);
      chk("ar_lat", bus.sync_latency, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ar_ready_rel", bus.cmd_ready, 1);
      chk("ar_error", bus.error, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/snes_reset_sequencer.md
# snes_reset_sequencer

Host-commanded power-on/reset sequencer that sits directly upstream of the master-clock divider / APU-CPU clock generator. On a start command it holds the divider reset (`mclkreset_n`), then the console reset (`console_reset_n`), releases them in order, and waits for the APU sync strobe and the generator's CPU-reset release. It reports the measured sync latency and a pass/fault status to the host. All logic runs in the PLL master-clock domain (~171.818 MHz).

## Interface
Parameters:
- `MCLK_HOLD`, 16: master cycles `mclkreset_n` is held low after command accept.
- `CON_HOLD_DEF`, 1024: console-reset hold cycles used when `cmd_hold == 0`.
- `SYNC_TIMEOUT`, 2^20: maximum cycles in WAIT_SYNC before fault.
- `CPU_TIMEOUT`, 4096: maximum cycles in WAIT_CPU before fault.
- `CNT_W`, 24: width of the cycle counter and of `sync_latency`; must be ≥ 24.

Ports:
- `clkin`  in  1  master clock (PLL global).
- `reset`  in  1  asynchronous, active-low block reset.
- `cmd_valid`  in  1  host start request.
- `cmd_ready`  out  1  start can be accepted.
- `cmd_hold`  in  16  console-reset hold in units of 256 cycles; 0 selects `CON_HOLD_DEF`.
- `apusync`  in  1  asynchronous, active-low APU sync strobe.
- `cpureset_in`  in  1  asynchronous CPU-reset release from the clock generator (1 = CPU running).
- `mclkreset_n`  out  1  divider reset, active-low.
- `console_reset_n`  out  1  console reset, active-low.
- `busy`, `done`, `error`  out  1 each  status flags.
- `sync_latency`  out  `CNT_W`  captured WAIT_SYNC count.

## Operation
- States: IDLE, MCLK_HOLD, CON_HOLD, WAIT_SYNC, WAIT_CPU, RUN, FAULT.
- Reset values, all registered: state IDLE, `cmd_ready` 0, `mclkreset_n` 0, `console_reset_n` 0, `busy`/`done`/`error` 0, `sync_latency` 0.
- `cmd_ready` is 1 in IDLE, RUN and FAULT, and 0 in every other state.
- A command is accepted when `cmd_valid && cmd_ready`. A command arriving while busy is ignored; there is no queue.
- On accept:
  - Next state MCLK_HOLD; counter cleared.
  - `mclkreset_n` and `console_reset_n` driven to 0; `busy` 1; `done`/`error` 0.
  - `cmd_hold` is latched.
- MCLK_HOLD: after `MCLK_HOLD` cycles, `mclkreset_n` goes to 1; go to CON_HOLD with the counter cleared.
- CON_HOLD:
  - Hold length H = `cmd_hold` × 256 (zero-extended to `CNT_W`), or `CON_HOLD_DEF` if `cmd_hold` is 0.
  - After H cycles, `console_reset_n` goes to 1; go to WAIT_SYNC with the counter cleared.
- WAIT_SYNC:
  - The counter increments every cycle.
  - On a 1→0 transition of the synchronized `apusync`: `sync_latency` ← counter, go to WAIT_CPU with the counter cleared.
  - If the counter reaches `SYNC_TIMEOUT`, go to FAULT.
  - If the edge and the timeout occur in the same cycle, the edge wins.
- WAIT_CPU:
  - When synchronized `cpureset_in` is 1, go to RUN.
  - If the counter reaches `CPU_TIMEOUT`, go to FAULT; release wins over a same-cycle timeout.
- RUN: `busy` 0, `done` 1. If synchronized `cpureset_in` falls to 0, go to FAULT.
- FAULT: `busy` 0, `error` 1, `console_reset_n` 0, `mclkreset_n` unchanged.
- RUN and FAULT hold until the next accepted command.
- Asserting `reset` at any point returns all state and outputs to their reset values immediately; an in-flight sequence is abandoned.

## Timing
- `apusync` and `cpureset_in` each pass through a 2-flop synchronizer. `apusync` then has one edge-detect register. Asynchronous input to in-block detection is therefore 2–3 cycles.
- `sync_latency` counts from the first WAIT_SYNC cycle (count 0), i.e. from the first cycle with `console_reset_n` = 1. The count includes synchronizer delay.
- `mclkreset_n` rises exactly `MCLK_HOLD` + 1 cycles after the accept edge.
- `console_reset_n` rises exactly H cycles after `mclkreset_n` rises.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Shared package `tastable_pkg` holds:
  - the state encoding constants;
  - the default hold and timeout constants;
  - the 256-cycle hold unit.
- Sub-module `sync_2ff` (two-flop synchronizer, reset to a parameterised idle value) is instantiated twice:
  - for `apusync`, idle value 1;
  - for `cpureset_in`, idle value 0.
- One counter, shared across all states.

## Test plan
Bench parameters: `MCLK_HOLD`=16, `CON_HOLD_DEF`=1024, `SYNC_TIMEOUT`=4096, `CPU_TIMEOUT`=256.
- Nominal run, `cmd_hold`=0, `apusync` low 300 cycles after `console_reset_n` rises, `cpureset_in` high 50 cycles later:
  - `mclkreset_n` rises at accept+17;
  - `console_reset_n` rises 1024 cycles later;
  - `sync_latency` ∈ [302,303];
  - `done`=1, `error`=0.
- `cmd_hold`=3 → `console_reset_n` rises exactly 768 cycles after `mclkreset_n`.
- No `apusync` → FAULT at 4096 WAIT_SYNC cycles:
  - `error`=1, `console_reset_n`=0, `mclkreset_n`=1, `cmd_ready`=1.
- `cpureset_in` drops during RUN → FAULT within 3 cycles, `console_reset_n`=0.
- `cmd_valid` pulsed during CON_HOLD → ignored, timing unchanged; a new command in RUN restarts the sequence with `done` cleared.
- `reset` asserted mid-WAIT_SYNC → all outputs at reset values the same cycle; `cmd_ready`=1 one cycle after release.
